// File: rtl/shared_alu_pkg.sv
// rtl/shared_alu_pkg.sv - shared types, opcodes and ALU evaluation for shared_alu_sched
//
// Purpose: common definitions imported by the scheduler and its arbiter.
//   DW        datapath width (4 bits)
//   OP_*      3-bit opcodes
//   state_t   result-register occupancy state
//   alu_eval  combinational evaluation of one op, including zero-divide rules
package shared_alu_pkg;

   localparam int DW = 4;

   localparam logic [2:0] OP_XOR  = 3'd0;
   localparam logic [2:0] OP_AND  = 3'd1;
   localparam logic [2:0] OP_OR   = 3'd2;
   localparam logic [2:0] OP_SLT  = 3'd3;
   localparam logic [2:0] OP_MUL  = 3'd4;
   localparam logic [2:0] OP_MOD  = 3'd5;
   localparam logic [2:0] OP_DIV  = 3'd6;
   localparam logic [2:0] OP_PASS = 3'd7;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   function automatic logic [DW-1:0] alu_eval(input logic [2:0]    op,
                                              input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
      logic signed [DW-1:0] sa;
      logic signed [DW-1:0] sb;
      logic [2*DW-1:0]      prod;
      logic [DW-1:0]        r;
      sa   = $signed(a);
      sb   = $signed(b);
      // Low half of a product is identical for signed and unsigned operands.
      prod = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
      r    = '0;
      case (op)
         OP_XOR: r = a ^ b;
         OP_AND: r = a & b;
         OP_OR:  r = a | b;
         OP_SLT: r = {{(DW-1){1'b0}}, (sa < sb)};
         OP_MUL: r = prod[DW-1:0];
         OP_MOD: begin
            if (b == '0)
               r = a;
            else if (a == {1'b1, {(DW-1){1'b0}}} && b == '1)
               r = '0; // most-negative % -1 overflows the quotient; remainder is 0
            else
               r = $unsigned(sa % sb);
         end
         OP_DIV: begin
            if (b == '0)
               r = '1;
            else
               r = a / b;
         end
         default: r = a;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/shared_alu_rr_arb.sv
// rtl/shared_alu_rr_arb.sv - NREQ-wide round-robin arbiter
//
// Purpose: picks the first valid requester at or above the pointer, wrapping.
// Ports:
//   valid_i  per-requester valid
//   en_i     arbitration enable; no grant when low
//   ptr_i    highest-priority index this cycle (< NREQ)
//   grant_o  one-hot grant
//   idx_o    encoded index of the granted requester
//   any_o    a grant was issued
module shared_alu_rr_arb #(
   parameter int NREQ = 4,
   parameter int IW   = 3
) (
   input  logic [NREQ-1:0] valid_i,
   input  logic            en_i,
   input  logic [IW-1:0]   ptr_i,
   output logic [NREQ-1:0] grant_o,
   output logic [IW-1:0]   idx_o,
   output logic            any_o
);

   logic [2*NREQ-1:0] dbl;
   logic [NREQ-1:0]   rot;
   logic [IW:0]       sum;

   always_comb begin
      // Rotate valids so the pointer position lands at bit 0; the first set
      // bit of the rotated vector is the distance from the pointer.
      dbl   = {valid_i, valid_i} >> ptr_i;
      rot   = dbl[NREQ-1:0];
      any_o = 1'b0;
      sum   = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (en_i && !any_o && rot[k]) begin
            any_o = 1'b1;
            sum   = {1'b0, ptr_i} + (IW+1)'(k);
         end
      end
      if (sum >= (IW+1)'(NREQ))
         sum = sum - (IW+1)'(NREQ);
      idx_o = sum[IW-1:0];
      for (int i = 0; i < NREQ; i++)
         grant_o[i] = any_o && (idx_o == IW'(i));
   end

endmodule

// File: rtl/shared_alu_sched.sv
// rtl/shared_alu_sched.sv - round-robin scheduler sharing one 4-bit ALU among NREQ requesters
//
// Purpose: arbitrates requests, issues one op per cycle into the shared ALU and
// holds the tagged result in a valid/ready output register.
// Optional feature macro: SHARED_ALU_STATS_EN (grant and stall counters).
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   req_valid/req_ready per-requester request handshake (req_ready one-hot)
//   req_op/req_a/req_b  per-requester opcode and operands, requester i in slice i
//   rsp_valid/rsp_ready result handshake
//   rsp_data, rsp_tag   result value and issuing requester index
//   stat_grants         (macro) per-requester saturating 8-bit grant counts
//   stat_stall          (macro) saturating count of blocked-request cycles
module shared_alu_sched
   import shared_alu_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int TAGW = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [3*NREQ-1:0] req_op,
   input  logic [DW*NREQ-1:0] req_a,
   input  logic [DW*NREQ-1:0] req_b,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DW-1:0]     rsp_data,
   output logic [TAGW-1:0]   rsp_tag
`ifdef SHARED_ALU_STATS_EN
   ,
   output logic [NREQ*8-1:0] stat_grants,
   output logic [7:0]        stat_stall
`endif
);

   state_t          state_q, state_d;
   logic [TAGW-1:0] ptr_q, ptr_d;
   logic [DW-1:0]   data_q, data_d;
   logic [TAGW-1:0] tag_q, tag_d;

   logic            can_issue;
   logic            arb_en;
   logic            any_grant;
   logic [NREQ-1:0] grant;
   logic [TAGW-1:0] grant_idx;

   logic [2:0]      sel_op;
   logic [DW-1:0]   sel_a;
   logic [DW-1:0]   sel_b;
   logic [DW-1:0]   alu_res;

   // Draining and refilling in the same cycle is allowed, so a held result
   // only blocks issue while the consumer is stalling.
   assign can_issue = (state_q == ST_EMPTY) || rsp_ready;
   assign arb_en    = can_issue && !reset;

   shared_alu_rr_arb #(
      .NREQ (NREQ),
      .IW   (TAGW)
   ) u_arb (
      .valid_i (req_valid),
      .en_i    (arb_en),
      .ptr_i   (ptr_q),
      .grant_o (grant),
      .idx_o   (grant_idx),
      .any_o   (any_grant)
   );

   // One-hot grant drives an AND-OR operand mux.
   always_comb begin
      sel_op = '0;
      sel_a  = '0;
      sel_b  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            sel_op = sel_op | req_op[3*i +: 3];
            sel_a  = sel_a  | req_a[DW*i +: DW];
            sel_b  = sel_b  | req_b[DW*i +: DW];
         end
      end
   end

   assign alu_res = alu_eval(sel_op, sel_a, sel_b);

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      data_d  = data_q;
      tag_d   = tag_q;
      if (any_grant) begin
         state_d = ST_FULL;
         data_d  = alu_res;
         tag_d   = grant_idx;
         ptr_d   = (grant_idx == TAGW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
      end else if (state_q == ST_FULL && rsp_ready) begin
         state_d = ST_EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_EMPTY;
         ptr_q   <= '0;
         data_q  <= '0;
         tag_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         data_q  <= data_d;
         tag_q   <= tag_d;
      end
   end

   assign req_ready = grant;
   assign rsp_valid = (state_q == ST_FULL);
   assign rsp_data  = data_q;
   assign rsp_tag   = tag_q;

`ifdef SHARED_ALU_STATS_EN
   logic [NREQ-1:0][7:0] gcnt_q, gcnt_d;
   logic [7:0]           stall_q, stall_d;

   always_comb begin
      gcnt_d  = gcnt_q;
      stall_d = stall_q;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i] && gcnt_q[i] != 8'hFF)
            gcnt_d[i] = gcnt_q[i] + 8'd1;
      end
      if (state_q == ST_FULL && !rsp_ready && |req_valid && stall_q != 8'hFF)
         stall_d = stall_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         gcnt_q  <= '0;
         stall_q <= '0;
      end else begin
         gcnt_q  <= gcnt_d;
         stall_q <= stall_d;
      end
   end

   assign stat_grants = gcnt_q;
   assign stat_stall  = stall_q;
`endif

endmodule

// File: tb/tb_shared_alu_sched.sv
// tb/tb_shared_alu_sched.sv - self-checking bench for shared_alu_sched
module tb_shared_alu_sched;

   localparam int N = 4;
   localparam int T = 3;

   logic           clk = 1'b0;
   logic           reset;
   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_ready;
   logic [3*N-1:0] req_op;
   logic [4*N-1:0] req_a;
   logic [4*N-1:0] req_b;
   logic           rsp_valid;
   logic           rsp_ready;
   logic [3:0]     rsp_data;
   logic [T-1:0]   rsp_tag;
`ifdef SHARED_ALU_STATS_EN
   logic [N*8-1:0] stat_grants;
   logic [7:0]     stat_stall;
`endif

   shared_alu_sched #(.NREQ(N), .TAGW(T)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_tag   (rsp_tag)
`ifdef SHARED_ALU_STATS_EN
      ,
      .stat_grants (stat_grants),
      .stat_stall  (stat_stall)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // requester-side pending requests
   logic [N-1:0] v_valid;
   logic [2:0]   v_op [N];
   logic [3:0]   v_a  [N];
   logic [3:0]   v_b  [N];

   // reference model of the result register and priority pointer
   logic       m_valid = 1'b0;
   logic [3:0] m_data  = '0;
   int         m_tag   = 0;
   int         m_ptr   = 0;
   logic [N-1:0] obs_grant;

   typedef struct {
      logic [2:0] op;
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] exp;
   } vec_t;
   vec_t vecs [14];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] ref_alu(input int op, input int a, input int b);
      int sa, sb, r;
      sa = (a > 7) ? a - 16 : a;
      sb = (b > 7) ? b - 16 : b;
      case (op)
         0: r = a ^ b;
         1: r = a & b;
         2: r = a | b;
         3: r = (sa < sb) ? 1 : 0;
         4: r = sa * sb;
         5: r = (b == 0) ? sa : sa % sb;
         6: r = (b == 0) ? 15 : a / b;
         default: r = a;
      endcase
      return r[3:0];
   endfunction

   task automatic set_req(input int i, input int op, input int a, input int b);
      v_valid[i] = 1'b1;
      v_op[i]    = 3'(op);
      v_a[i]     = 4'(a);
      v_b[i]     = 4'(b);
   endtask

   // One clock: drive at negedge, check against the model, then advance the model on posedge.
   task automatic step(input logic rst, input logic rdy);
      int g;
      logic [N-1:0] exp_rdy;
      @(negedge clk);
      reset     = rst;
      rsp_ready = rdy;
      for (int i = 0; i < N; i++) begin
         req_valid[i]       = v_valid[i];
         req_op[3*i +: 3]   = v_op[i];
         req_a[4*i +: 4]    = v_a[i];
         req_b[4*i +: 4]    = v_b[i];
      end
      #1;
      g = -1;
      if (!rst && (!m_valid || rdy)) begin
         for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (g < 0 && v_valid[j]) g = j;
         end
      end
      exp_rdy = (g >= 0) ? N'(1 << g) : '0;
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
      if (m_valid) begin
         chk("rsp_data", 32'(rsp_data), 32'(m_data));
         chk("rsp_tag", 32'(rsp_tag), m_tag);
      end
      obs_grant = req_ready;
      @(posedge clk);
      if (rst) begin
         m_valid = 1'b0;
         m_data  = '0;
         m_tag   = 0;
         m_ptr   = 0;
      end else if (g >= 0) begin
         m_valid    = 1'b1;
         m_data     = ref_alu(int'(v_op[g]), int'(v_a[g]), int'(v_b[g]));
         m_tag      = g;
         m_ptr      = (g + 1) % N;
         v_valid[g] = 1'b0;
      end else if (rdy) begin
         m_valid = 1'b0;
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [3:0] held;
      vecs[0]  = '{3'd0, 4'hA, 4'h5, 4'hF};
      vecs[1]  = '{3'd1, 4'hC, 4'hA, 4'h8};
      vecs[2]  = '{3'd2, 4'h1, 4'h8, 4'h9};
      vecs[3]  = '{3'd3, 4'hF, 4'h1, 4'h1};
      vecs[4]  = '{3'd3, 4'h1, 4'hF, 4'h0};
      vecs[5]  = '{3'd4, 4'h8, 4'hF, 4'h8};
      vecs[6]  = '{3'd4, 4'h3, 4'h5, 4'hF};
      vecs[7]  = '{3'd5, 4'h5, 4'h0, 4'h5};
      vecs[8]  = '{3'd5, 4'h8, 4'hF, 4'h0};
      vecs[9]  = '{3'd5, 4'h9, 4'h2, 4'hF};
      vecs[10] = '{3'd5, 4'h7, 4'hE, 4'h1};
      vecs[11] = '{3'd6, 4'h7, 4'h0, 4'hF};
      vecs[12] = '{3'd6, 4'hE, 4'h3, 4'h4};
      vecs[13] = '{3'd7, 4'h6, 4'h9, 4'h6};

      for (int i = 0; i < N; i++) set_req(i, 7, i, 0);
      reset     = 1'b1;
      rsp_ready = 1'b0;
      req_valid = '1;
      req_op    = '0;
      req_a     = '0;
      req_b     = '0;
      @(posedge clk);

      // reset held with every requester valid
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      #2;
      chk("reset_rsp_valid", 32'(rsp_valid), 0);
      chk("reset_rsp_data", 32'(rsp_data), 0);
      chk("reset_rsp_tag", 32'(rsp_tag), 0);

      // all valid, consumer always ready: strict rotation with no bubbles
      for (int k = 0; k < 5; k++) begin
         for (int i = 0; i < N; i++)
            if (!v_valid[i]) set_req(i, 0, k, i);
         step(1'b0, 1'b1);
         chk("rr_grant", 32'(obs_grant), 32'(1 << (k % N)));
      end
      v_valid = '0;

      // operation table through requester 2
      for (int t = 0; t < 14; t++) begin
         set_req(2, int'(vecs[t].op), int'(vecs[t].a), int'(vecs[t].b));
         step(1'b0, 1'b1);
         #2;
         chk("alu_data", 32'(rsp_data), 32'(vecs[t].exp));
         chk("alu_tag", 32'(rsp_tag), 2);
      end

      // backpressure: held result stays put and nothing is accepted
      held = vecs[13].exp;
      set_req(1, 0, 3, 5);
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 1'b0);
         #2;
         chk("stall_data", 32'(rsp_data), 32'(held));
         chk("stall_tag", 32'(rsp_tag), 2);
         chk("stall_valid", 32'(rsp_valid), 1);
      end
      step(1'b0, 1'b1);
      chk("drain_accept", 32'(obs_grant), 32'(4'b0010));
      #2;
      chk("drain_tag", 32'(rsp_tag), 1);
      chk("drain_data", 32'(rsp_data), 32'(4'h6));

      // reset while FULL with a pending request
      set_req(3, 2, 1, 2);
      step(1'b1, 1'b0);
      #2;
      chk("midreset_valid", 32'(rsp_valid), 0);
`ifdef SHARED_ALU_STATS_EN
      chk("midreset_grants", 32'(stat_grants), 0);
      chk("midreset_stall", 32'(stat_stall), 0);
`endif
      for (int i = 0; i < N; i++)
         if (!v_valid[i]) set_req(i, 1, 15, i);
      step(1'b0, 1'b1);
      chk("midreset_ptr", 32'(obs_grant), 32'(4'b0001));

      // randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!v_valid[i] && ($urandom % 2 == 0)) begin
               int bb;
               bb = ($urandom % 5 == 0) ? 0 : int'($urandom_range(0, 15));
               set_req(i, int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), bb);
            end
         end
         step(($urandom % 100) == 0, ($urandom % 4) != 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
